// File: rtl/aqp_io_fifo_port.sv
// aqp_io_fifo_port: Z80 I/O-mapped mailbox target with a TX FIFO (core to CPU)
// and an RX FIFO (CPU to core). The data port is BASE_PORT and the status port
// is BASE_PORT+1. Bus strobes are synchronised and edge-detected. Read data and
// the output enable are combinational from the raw pins and the FIFO/status state.
module aqp_io_fifo_port #(
    parameter logic [7:0] BASE_PORT  = 8'hF6,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ebus_a,
    input  logic [7:0] ebus_d,
    input  logic       ebus_rd_n,
    input  logic       ebus_wr_n,
    input  logic       ebus_iorq_n,
    output logic [7:0] ebus_d_out,
    output logic       ebus_d_oe,
    output logic       irq,
    input  logic [7:0] core_tx_data,
    input  logic       core_tx_wr,
    output logic       core_tx_full,
    output logic [7:0] core_rx_data,
    input  logic       core_rx_rd,
    output logic       core_rx_empty
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = CNT_ONE[DEPTH_LOG2-1:0];

    // Strobe synchronisers. Bit 2 is the oldest sample.
    logic [2:0] r_rd_sync;
    logic [2:0] r_wr_sync;
    // r_live marks that stage 0 now holds a pin sample rather than the reset value.
    // The armed flags stay low until a strobe has been seen high after reset.
    // This keeps a strobe that was already low at reset release from producing a
    // false falling edge.
    logic       r_live;
    logic       r_rd_armed;
    logic       r_wr_armed;
    logic       r_rd_hit;
    logic       r_rd_sel;
    logic       r_irq_en;
    logic       r_ovf;
    logic       r_irq;

    logic [7:0]            r_tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wptr;
    logic [DEPTH_LOG2-1:0] r_tx_rptr;
    logic [DEPTH_LOG2:0]   r_tx_cnt;
    logic [7:0]            r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rx_wptr;
    logic [DEPTH_LOG2-1:0] r_rx_rptr;
    logic [DEPTH_LOG2:0]   r_rx_cnt;

    logic       w_rd_fall;
    logic       w_rd_rise;
    logic       w_wr_fall;
    logic       w_port_match;
    logic       w_decode;
    logic       w_wr_data;
    logic       w_wr_stat;
    logic       w_flush;
    logic       w_tx_full;
    logic       w_tx_nonempty;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_tx_push;
    logic       w_tx_pop;
    logic       w_rx_push;
    logic       w_rx_pop;
    logic       w_rx_ovf;
    logic       w_ovf_clr;
    logic [7:0] w_status;
    logic [7:0] w_tx_head;

    assign w_rd_fall     = r_rd_armed && (r_rd_sync[2:1] == 2'b10);
    assign w_rd_rise     = (r_rd_sync[2:1] == 2'b01);
    assign w_wr_fall     = r_wr_armed && (r_wr_sync[2:1] == 2'b10);
    assign w_port_match  = (ebus_a[7:1] == BASE_PORT[7:1]);
    assign w_decode      = !ebus_iorq_n && w_port_match;
    assign w_wr_data     = w_wr_fall && w_decode && !ebus_a[0];
    assign w_wr_stat     = w_wr_fall && w_decode && ebus_a[0];
    assign w_flush       = w_wr_stat && ebus_d[7];

    assign w_tx_full     = (r_tx_cnt == CNT_FULL);
    assign w_tx_nonempty = (r_tx_cnt != {(DEPTH_LOG2+1){1'b0}});
    assign w_rx_full     = (r_rx_cnt == CNT_FULL);
    assign w_rx_empty    = (r_rx_cnt == {(DEPTH_LOG2+1){1'b0}});

    // Each FIFO operation must be legal on its own. A flush discards both.
    assign w_tx_push = core_tx_wr && !w_tx_full && !w_flush;
    assign w_tx_pop  = w_rd_rise && r_rd_hit && !r_rd_sel && w_tx_nonempty && !w_flush;
    assign w_rx_push = w_wr_data && !w_rx_full && !w_flush;
    assign w_rx_pop  = core_rx_rd && !w_rx_empty && !w_flush;
    assign w_rx_ovf  = w_wr_data && w_rx_full;
    assign w_ovf_clr = w_rd_rise && r_rd_hit && r_rd_sel;

    assign w_status  = {4'b0000, r_irq_en, r_ovf, w_rx_full, w_tx_nonempty};
    assign w_tx_head = w_tx_nonempty ? r_tx_mem[r_tx_rptr] : 8'h00;

    assign ebus_d_oe     = !ebus_iorq_n && !ebus_rd_n && w_port_match;
    assign ebus_d_out    = ebus_d_oe ? (ebus_a[0] ? w_status : w_tx_head) : 8'h00;
    assign irq           = r_irq;
    assign core_tx_full  = w_tx_full;
    assign core_rx_empty = w_rx_empty;
    assign core_rx_data  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];

    // Strobe synchronisers, post-reset arming, and read hit/port-select latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_sync  <= 3'b111;
            r_wr_sync  <= 3'b111;
            r_live     <= 1'b0;
            r_rd_armed <= 1'b0;
            r_wr_armed <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_rd_sel   <= 1'b0;
        end else begin
            r_rd_sync  <= {r_rd_sync[1:0], ebus_rd_n};
            r_wr_sync  <= {r_wr_sync[1:0], ebus_wr_n};
            r_live     <= 1'b1;
            r_rd_armed <= r_rd_armed | (r_live & r_rd_sync[0]);
            r_wr_armed <= r_wr_armed | (r_live & r_wr_sync[0]);
            if (w_rd_fall) begin
                r_rd_hit <= w_decode;
                r_rd_sel <= ebus_a[0];
            end else if (w_rd_rise) begin
                r_rd_hit <= 1'b0;
            end
        end
    end

    // Status registers and the registered interrupt. A flush clears ovf. A new
    // overflow wins over a status-read clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_stat) begin
                r_irq_en <= ebus_d[3];
            end
            if (w_flush) begin
                r_ovf <= 1'b0;
            end else if (w_rx_ovf) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            r_irq <= r_irq_en && w_tx_nonempty;
        end
    end

    // TX FIFO pointers and count. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_wptr <= {DEPTH_LOG2{1'b0}};
            r_tx_rptr <= {DEPTH_LOG2{1'b0}};
            r_tx_cnt  <= {(DEPTH_LOG2+1){1'b0}};
        end else if (w_flush) begin
            r_tx_wptr <= {DEPTH_LOG2{1'b0}};
            r_tx_rptr <= {DEPTH_LOG2{1'b0}};
            r_tx_cnt  <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_ONE;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CNT_ONE;
                2'b01:   r_tx_cnt <= r_tx_cnt - CNT_ONE;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // RX FIFO pointers and count. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_wptr <= {DEPTH_LOG2{1'b0}};
            r_rx_rptr <= {DEPTH_LOG2{1'b0}};
            r_rx_cnt  <= {(DEPTH_LOG2+1){1'b0}};
        end else if (w_flush) begin
            r_rx_wptr <= {DEPTH_LOG2{1'b0}};
            r_rx_rptr <= {DEPTH_LOG2{1'b0}};
            r_rx_cnt  <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_ONE;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CNT_ONE;
                2'b01:   r_rx_cnt <= r_rx_cnt - CNT_ONE;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // FIFO storage. Entries are only read while the FIFO is non-empty, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= core_tx_data;
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= ebus_d;
    end

endmodule

// File: tb/tb_aqp_io_fifo_port.sv
// Directed bench for aqp_io_fifo_port. Inputs are driven on the falling clock
// edge and outputs are sampled on the falling edge.
module tb_aqp_io_fifo_port;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ebus_a;
    logic [7:0] ebus_d;
    logic       ebus_rd_n;
    logic       ebus_wr_n;
    logic       ebus_iorq_n;
    logic [7:0] ebus_d_out;
    logic       ebus_d_oe;
    logic       irq;
    logic [7:0] core_tx_data;
    logic       core_tx_wr;
    logic       core_tx_full;
    logic [7:0] core_rx_data;
    logic       core_rx_rd;
    logic       core_rx_empty;

    int checks = 0;
    int errors = 0;

    aqp_io_fifo_port #(.BASE_PORT(8'hF6), .DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset),
        .ebus_a(ebus_a), .ebus_d(ebus_d),
        .ebus_rd_n(ebus_rd_n), .ebus_wr_n(ebus_wr_n), .ebus_iorq_n(ebus_iorq_n),
        .ebus_d_out(ebus_d_out), .ebus_d_oe(ebus_d_oe), .irq(irq),
        .core_tx_data(core_tx_data), .core_tx_wr(core_tx_wr), .core_tx_full(core_tx_full),
        .core_rx_data(core_rx_data), .core_rx_rd(core_rx_rd), .core_rx_empty(core_rx_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic core_push(input logic [7:0] d);
        core_tx_data = d;
        core_tx_wr   = 1'b1;
        @(negedge clk);
        core_tx_wr   = 1'b0;
    endtask

    task automatic core_pop();
        core_rx_rd = 1'b1;
        @(negedge clk);
        core_rx_rd = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        ebus_a = a; ebus_d = d; ebus_iorq_n = 1'b0; ebus_wr_n = 1'b0;
        repeat (8) @(negedge clk);
        ebus_wr_n = 1'b1; ebus_iorq_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
        ebus_a = a; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0;
        repeat (6) @(negedge clk);
        check(tag, ebus_d_out, exp);
        ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; ebus_a = 8'h00; ebus_d = 8'h00;
        ebus_rd_n = 1'b1; ebus_wr_n = 1'b1; ebus_iorq_n = 1'b1;
        core_tx_data = 8'h00; core_tx_wr = 1'b0; core_rx_rd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_oe", {7'd0, ebus_d_oe}, 8'h00);
        check("rst_irq", {7'd0, irq}, 8'h00);
        check("rst_tx_full", {7'd0, core_tx_full}, 8'h00);
        check("rst_rx_empty", {7'd0, core_rx_empty}, 8'h01);
        check("rst_d_out", ebus_d_out, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Core to CPU path
        core_push(8'h11);
        core_push(8'h22);
        cpu_read(8'hF7, 8'h01, "tx_stat1");
        cpu_read(8'hF6, 8'h11, "tx_rd11");
        cpu_read(8'hF6, 8'h22, "tx_rd22");
        cpu_read(8'hF7, 8'h00, "tx_stat0");
        cpu_read(8'hF6, 8'h00, "tx_rd_empty");
        cpu_read(8'hF7, 8'h00, "tx_stat_after_empty");

        // CPU to core path: fill the RX FIFO, then overflow it
        cpu_write(8'hF6, 8'h41);
        check("rx_empty_first", {7'd0, core_rx_empty}, 8'h00);
        for (int i = 1; i < 16; i++) cpu_write(8'hF6, 8'h41 + 8'(i));
        cpu_read(8'hF7, 8'h02, "rx_stat_full");
        cpu_write(8'hF6, 8'h99);
        cpu_read(8'hF7, 8'h06, "rx_stat_ovf");
        cpu_read(8'hF7, 8'h02, "rx_stat_ovf_clr");
        for (int i = 0; i < 16; i++) begin
            check("rx_pop_data", core_rx_data, 8'h41 + 8'(i));
            core_pop();
        end
        check("rx_empty_drained", {7'd0, core_rx_empty}, 8'h01);

        // Interrupt
        cpu_write(8'hF7, 8'h08);
        core_push(8'h5A);
        check("irq_lat0", {7'd0, irq}, 8'h00);
        @(negedge clk);
        check("irq_lat1", {7'd0, irq}, 8'h01);
        cpu_read(8'hF6, 8'h5A, "irq_rd5a");
        check("irq_cleared", {7'd0, irq}, 8'h00);

        // Push in the same cycle as a CPU pop, with one byte queued
        core_push(8'h77);
        ebus_a = 8'hF6; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0;
        repeat (6) @(negedge clk);
        check("same_rd77", ebus_d_out, 8'h77);
        ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        core_tx_data = 8'h88; core_tx_wr = 1'b1;
        @(negedge clk);
        core_tx_wr = 1'b0;
        repeat (4) @(negedge clk);
        cpu_read(8'hF7, 8'h09, "same_stat_cnt1");
        cpu_read(8'hF6, 8'h88, "same_rd88");
        cpu_read(8'hF7, 8'h08, "same_stat_empty");

        // Flush with both FIFOs non-empty and ovf set
        for (int i = 0; i < 17; i++) cpu_write(8'hF6, 8'(i));
        core_push(8'hA1);
        core_push(8'hA2);
        repeat (2) @(negedge clk);
        check("fl_pre_irq", {7'd0, irq}, 8'h01);
        check("fl_pre_rx_empty", {7'd0, core_rx_empty}, 8'h00);
        cpu_write(8'hF7, 8'h80);
        cpu_read(8'hF7, 8'h00, "fl_stat");
        check("fl_rx_empty", {7'd0, core_rx_empty}, 8'h01);
        check("fl_irq", {7'd0, irq}, 8'h00);
        cpu_read(8'hF6, 8'h00, "fl_rd_empty");

        // Unmapped ports and memory cycles
        core_push(8'hC3);
        ebus_a = 8'hF8; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0;
        repeat (6) @(negedge clk);
        check("um_oe_f8", {7'd0, ebus_d_oe}, 8'h00);
        check("um_dout_f8", ebus_d_out, 8'h00);
        ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
        repeat (5) @(negedge clk);
        ebus_a = 8'hF6; ebus_iorq_n = 1'b1; ebus_rd_n = 1'b0;
        repeat (6) @(negedge clk);
        check("um_oe_mem", {7'd0, ebus_d_oe}, 8'h00);
        ebus_rd_n = 1'b1;
        repeat (5) @(negedge clk);
        cpu_write(8'hF8, 8'h12);
        cpu_write(8'hF9, 8'h80);
        ebus_a = 8'hF6; ebus_d = 8'h34; ebus_iorq_n = 1'b1; ebus_wr_n = 1'b0;
        repeat (8) @(negedge clk);
        ebus_wr_n = 1'b1;
        repeat (5) @(negedge clk);
        check("um_rx_empty", {7'd0, core_rx_empty}, 8'h01);
        cpu_read(8'hF7, 8'h01, "um_stat");

        // Reset pulse in the middle of a data read
        ebus_a = 8'hF6; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mr_oe", {7'd0, ebus_d_oe}, 8'h00);
        check("mr_irq", {7'd0, irq}, 8'h00);
        check("mr_tx_full", {7'd0, core_tx_full}, 8'h00);
        check("mr_rx_empty", {7'd0, core_rx_empty}, 8'h01);
        check("mr_dout", ebus_d_out, 8'h00);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        cpu_read(8'hF7, 8'h00, "mr_stat");

        // A write strobe already low at reset release is ignored
        reset = 1'b1;
        ebus_a = 8'hF6; ebus_d = 8'hAB; ebus_iorq_n = 1'b0; ebus_wr_n = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        ebus_wr_n = 1'b1; ebus_iorq_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rl_rx_empty", {7'd0, core_rx_empty}, 8'h01);
        cpu_write(8'hF6, 8'h5C);
        check("rl_rx_empty_after", {7'd0, core_rx_empty}, 8'h00);
        check("rl_rx_data", core_rx_data, 8'h5C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aqp_io_fifo_port.md
# aqp_io_fifo_port

Z80 I/O-mapped mailbox responder on the external bus. It answers CPU I/O reads and writes at two consecutive port addresses and buffers bytes in both directions between the CPU and the core logic. The bus master is either the external Z80 or the T80; this block is always the target, so it decodes and responds to cycles and never drives the address or control lines. It is instantiated beside the core common logic and shares its data-out multiplexing.

## Interface
Parameters:
- BASE_PORT, 8'hF6: data port address; the status port is BASE_PORT+1. BASE_PORT must be even.
- DEPTH_LOG2, 4: log2 of the depth of each FIFO (16 entries).

Ports:
- clk  in  1  system clock, 28.63636 MHz
- reset  in  1  asynchronous, active-high
- ebus_a  in  8  low byte of the bus address (the I/O port)
- ebus_d  in  8  bus data, sampled on a write
- ebus_rd_n, ebus_wr_n, ebus_iorq_n  in  1 each  raw Z80 bus strobes
- ebus_d_out  out  8  read data
- ebus_d_oe  out  1  drive enable for ebus_d
- irq  out  1  active-high level interrupt request
- core_tx_data  in  8  byte pushed by the core toward the CPU
- core_tx_wr  in  1  push strobe, one cycle per byte
- core_tx_full  out  1  TX FIFO full
- core_rx_data  out  8  show-ahead head of the RX FIFO (CPU to core)
- core_rx_rd  in  1  pop strobe for the RX FIFO
- core_rx_empty  out  1  RX FIFO empty

## Operation
Strobe synchronization:
- ebus_rd_n and ebus_wr_n each pass through a 3-flop shift register, reset to 1.
- A falling edge is stage[2:1]==2'b10; a rising edge is stage[2:1]==2'b01.

Hit decode:
- On a falling edge, the block evaluates iorq_n==0 && ebus_a[7:1]==BASE_PORT[7:1].
- It latches a hit flag and the port select (ebus_a[0]). The flag is held until the matching rising edge.

Data port write (ebus_a[0]=0):
- On the write falling edge, ebus_d is pushed into the RX FIFO.
- If the RX FIFO is full, the byte is dropped and ovf is set.

Status port write (ebus_a[0]=1):
- irq_en is loaded from d[3].
- If d[7]=1, both FIFOs are flushed and ovf is cleared. Pushes and pops in the same cycle are discarded.

Data port read:
- ebus_d_out = TX head (show-ahead), or 8'h00 if the TX FIFO is empty.
- The pop happens on the read rising edge if the TX FIFO is not empty. An empty read does not pop.

Status port read:
- ebus_d_out = {4'b0, irq_en, ovf, rx_full, tx_nonempty}.
- ovf is cleared on the read rising edge.
- If an overflow is set in the same cycle as that clear, the set wins.

Output enable and interrupt:
- ebus_d_oe = !ebus_iorq_n && !ebus_rd_n && ebus_a[7:1]==BASE_PORT[7:1]. This is combinational from the raw pins.
- irq = irq_en && tx_nonempty.

FIFOs:
- Each FIFO has DEPTH_LOG2-bit pointers that wrap and a DEPTH_LOG2+1-bit count.
- A push and a pop in the same cycle are both performed; the count is unchanged. This also holds when the FIFO is full or empty, provided the individual operation is legal.
- A core_tx_wr while full is ignored. A core_rx_rd while empty is ignored.

## Timing
Reset values:
- ebus_d_oe=0, irq=0, core_tx_full=0, core_rx_empty=1.
- ebus_d_out reads as 8'h00.
- irq_en=0, ovf=0, pointers and counts 0, sync stages all 1.

Latencies:
- Falling edge detected 3 clk after the pin falls. Write data is sampled in that cycle, which is well inside the ≥2 phi (≈16 clk) WR-low window.
- core_rx_empty deasserts 1 clk after the push.
- TX pop occurs 3 clk after RD rises. ebus_d_out stays stable for the whole RD-low interval because the pop only happens after RD rises.
- ebus_d_out updates in the clk after a pop, flush or status change. It is combinational from the FIFO head and the status registers.
- irq follows tx_nonempty and irq_en with 1 clk latency after the register update.

Reset behaviour:
- Reset asserted mid-cycle aborts it. The hit flags clear and no push or pop completes.
- A cycle whose strobe was already low when reset released is ignored, because no falling edge is seen.

## Test plan
- Core pushes 0x11, 0x22 → status read = 0x01 → data reads return 0x11, then 0x22 → next status read = 0x00 → data read of the empty FIFO returns 0x00 with no pointer change.
- CPU writes 0x41..0x50 (16 bytes) to the data port → core_rx_empty=0 and status bit1=1 → 17th write 0x99 is dropped → status read = 0x06, following status read = 0x02 → core pops 0x41..0x50 in order.
- Status write 0x08, then core push 0x5A → irq=1 one clk after push → CPU data read returns 0x5A → irq=0 after the pop.
- core_tx_wr asserted in the same clk as the CPU read pop, with TX count=1 → count stays 1 → new byte readable next.
- Status write 0x80 with both FIFOs non-empty and ovf set → all counts 0, status reads 0x00, core_rx_empty=1.
- Reads and writes to BASE_PORT+2, and memory cycles (iorq_n=1) at address 0xF6 → ebus_d_oe=0, no FIFO change; reset pulse mid-read → no pop and all outputs at reset values.
